// File: rtl/pong_pkg.sv
// Matrix geometry, scan state encoding and "all off" drive patterns shared by
// the LED scan controller and the game-update logic.
package pong_pkg;
    localparam int WIDTH    = 15;
    localparam int HEIGHT   = 10;
    localparam int ROW_BITS = 4;

    localparam logic [WIDTH-1:0]  H_OFF = {WIDTH{1'bz}};
    localparam logic [HEIGHT-1:0] V_OFF = {HEIGHT{1'bz}};

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;
endpackage

// File: rtl/led_scan_ctrl_if.sv
// Row-write and buffer-swap port between the game logic (master) and the scan
// controller (slave).
interface led_scan_ctrl_if;
    import pong_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    logic [ROW_BITS-1:0] wr_row;
    logic [WIDTH-1:0]    wr_data;
    logic                swap_req;
    logic                swap_ack;

    modport master (
        output wr_valid, wr_row, wr_data, swap_req,
        input  wr_ready, swap_ack
    );

    modport slave (
        input  wr_valid, wr_row, wr_data, swap_req,
        output wr_ready, swap_ack
    );
endinterface

// File: rtl/led_frame_buf.sv
// Two HEIGHT x WIDTH frame stores: registered write port, combinational row read.
// Writes to rows at or beyond HEIGHT are dropped; no backpressure.
module led_frame_buf
    import pong_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                wsel,
    input  logic [ROW_BITS-1:0] wrow,
    input  logic [WIDTH-1:0]    wdat,
    input  logic                rsel,
    input  logic [ROW_BITS-1:0] rrow,
    output logic [WIDTH-1:0]    rdat
);
    logic [WIDTH-1:0] mem [2][HEIGHT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < HEIGHT; r++) begin
                    mem[b][r] <= '0;
                end
            end
        end else if (we && (wrow < ROW_BITS'(HEIGHT))) begin
            mem[wsel][wrow] <= wdat;
        end
    end

    always_comb begin
        rdat = '0;
        if (rrow < ROW_BITS'(HEIGHT)) begin
            rdat = mem[rsel][rrow];
        end
    end
endmodule

// File: rtl/led_scan_ctrl.sv
// Row-scan sequencer over a double-buffered frame store; LED drive decodes
// combinationally from registered state. Writes stall only in the swap-sample cycle.
module led_scan_ctrl
    import pong_pkg::*;
#(
    parameter int DWELL_CYC = 1000,
    parameter int BLANK_CYC = 50
) (
    input  logic              p_clk12,
    input  logic              p_rst,
    led_scan_ctrl_if.slave    wr,
    output logic              frame_start,
    output wire [WIDTH-1:0]   p_hLED,
    output wire [HEIGHT-1:0]  p_vLED
);
    localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [ROW_BITS-1:0] LAST_ROW   = ROW_BITS'(HEIGHT - 1);
    localparam logic [HEIGHT-1:0]   V_ONE      = HEIGHT'(1);
    // With no blanking interval every row starts directly in ON.
    localparam scan_state_t FIRST_STATE = (BLANK_CYC > 0) ? BLANK : ON;

    scan_state_t         state, state_nxt;
    logic [ROW_BITS-1:0] row, row_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                front_sel;
    logic                swap_ack_q;
    logic                frame_end;
    logic                swap_now;
    logic                wr_fire;
    logic [WIDTH-1:0]    front_row;
    logic [WIDTH-1:0]    h_sink;
    logic [HEIGHT-1:0]   v_drive;

    assign frame_end   = (state == ON) && (cnt == DWELL_LAST) && (row == LAST_ROW);
    assign swap_now    = frame_end && wr.swap_req;
    assign wr.wr_ready = !p_rst && !swap_now;
    assign wr.swap_ack = swap_ack_q;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;

    led_frame_buf u_buf (
        .clk  (p_clk12),
        .rst  (p_rst),
        .we   (wr_fire),
        .wsel (~front_sel),
        .wrow (wr.wr_row),
        .wdat (wr.wr_data),
        .rsel (front_sel),
        .rrow (row),
        .rdat (front_row)
    );

    always_ff @(posedge p_clk12) begin
        if (p_rst) begin
            state      <= FIRST_STATE;
            row        <= '0;
            cnt        <= '0;
            front_sel  <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            row        <= row_nxt;
            cnt        <= cnt_nxt;
            swap_ack_q <= swap_now;
            if (swap_now) begin
                front_sel <= ~front_sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        cnt_nxt   = cnt + 1'b1;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end
            end
            ON: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt = FIRST_STATE;
                    cnt_nxt   = '0;
                    row_nxt   = (row == LAST_ROW) ? '0 : row + 1'b1;
                end
            end
            default: begin
                state_nxt = FIRST_STATE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        v_drive = '0;
        h_sink  = '0;
        if (state == ON) begin
            v_drive = V_ONE << row;
            h_sink  = front_row;
        end
        frame_start = !p_rst && (state == FIRST_STATE) && (row == '0) && (cnt == '0);
    end

    // Open-drain style pads: only actively driven bits leave high impedance.
    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        assign p_hLED[i] = h_sink[i] ? 1'b0 : 1'bz;
    end
    for (genvar j = 0; j < HEIGHT; j++) begin : g_row
        assign p_vLED[j] = v_drive[j] ? 1'b1 : 1'bz;
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_led_scan_ctrl;
    import pong_pkg::*;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int ROWP  = DW + BL;
    localparam int FRAME = HEIGHT * ROWP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start;
    // Pulls turn high impedance into a readable level: off column reads 1, off row reads 0.
    tri1 [WIDTH-1:0]  h_net;
    tri0 [HEIGHT-1:0] v_net;

    led_scan_ctrl_if bus ();

    led_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
        .p_clk12     (clk),
        .p_rst       (rst),
        .wr          (bus),
        .frame_start (frame_start),
        .p_hLED      (h_net),
        .p_vLED      (v_net)
    );

    always #5 clk = ~clk;

    int               n_chk  = 0;
    int               n_fail = 0;
    int               cyc    = 0;
    int               t      = 0;
    bit               live   = 1'b0;
    bit               m_front;
    bit               m_ack;
    logic [WIDTH-1:0] m_buf [2][HEIGHT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (frame pos %0d, cycle %0d)", name, act, exp, t, cyc);
        end
    endtask

    task automatic compare();
        int                row;
        bit                on;
        logic [WIDTH-1:0]  eh;
        logic [HEIGHT-1:0] ev;
        row = t / ROWP;
        on  = (t % ROWP) >= BL;
        ev  = on ? (HEIGHT'(1) << row) : '0;
        eh  = on ? ~m_buf[m_front][row] : {WIDTH{1'b1}};
        chk("p_vLED", 32'(v_net), 32'(ev));
        chk("p_hLED", 32'(h_net), 32'(eh));
        chk("frame_start", 32'(frame_start), 32'(!rst && t == 0));
        chk("swap_ack", 32'(bus.swap_ack), 32'(m_ack));
        chk("wr_ready", 32'(bus.wr_ready), 32'(!rst && !(t == FRAME - 1 && bus.swap_req)));
    endtask

    task automatic advance();
        bit swap;
        if (rst) begin
            t = 0; m_front = 1'b0; m_ack = 1'b0; live = 1'b1;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < HEIGHT; r++) m_buf[b][r] = '0;
        end else begin
            swap = (t == FRAME - 1) && bus.swap_req;
            if (bus.wr_valid && !swap && bus.wr_row < HEIGHT)
                m_buf[!m_front][bus.wr_row] = bus.wr_data;
            m_ack = swap;
            if (swap) m_front = !m_front;
            t = (t + 1) % FRAME;
        end
    endtask

    task automatic step();
        #1;
        if (live) compare();
        advance();
        cyc++;
        @(negedge clk);
    endtask

    task automatic goto_t(input int target);
        for (int i = 0; i <= FRAME && t != target; i++) step();
    endtask

    task automatic do_swap();
        int n;
        n = 0;
        bus.swap_req = 1'b1;
        while (n < 2 * FRAME) begin
            #1;
            if (bus.swap_ack) break;
            step();
            n++;
        end
        chk("swap_ack_seen", 32'(n < 2 * FRAME), 1);
        chk("ack_with_frame_start", 32'(frame_start), 1);
        bus.swap_req = 1'b0;
    endtask

    task automatic frame_all_dark(input string name);
        for (int c = 0; c < FRAME; c++) begin
            #1;
            if ((t % ROWP) >= BL) chk(name, 32'(h_net), 32'h7fff);
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs_seen, acks, last, extra;
        bus.wr_valid = 1'b0;
        bus.wr_row   = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;

        // Reset release: frame_start at cycle 0, blank then row 0, 60-cycle period.
        repeat (3) step();
        rst = 1'b0;
        fs_seen = 0;
        for (int c = 0; c <= FRAME; c++) begin
            #1;
            if (c == 0 || c == FRAME) chk("frame_start_period", 32'(frame_start), 1);
            if (c < 2) begin
                chk("blank_v", 32'(v_net), 0);
                chk("blank_h", 32'(h_net), 32'h7fff);
            end else if (c < 6) begin
                chk("row0_v", 32'(v_net), 32'h001);
                chk("row0_h", 32'(h_net), 32'h7fff);
            end
            if (c > 0 && c < FRAME) fs_seen += int'(frame_start);
            step();
        end
        chk("frame_start_gap", 32'(fs_seen), 0);

        // Out-of-range row write is accepted and discarded.
        bus.wr_valid = 1'b1; bus.wr_row = 4'd12; bus.wr_data = 15'h7fff;
        #1;
        chk("wr_ready_row12", 32'(bus.wr_ready), 1);
        step();
        bus.wr_valid = 1'b0;
        do_swap();
        frame_all_dark("row12_discard_h");

        // Row 3 pattern shows after swap.
        bus.wr_valid = 1'b1; bus.wr_row = 4'd3; bus.wr_data = 15'h0005;
        step();
        bus.wr_valid = 1'b0;
        do_swap();
        goto_t(3 * ROWP + BL);
        #1;
        chk("row3_h", 32'(h_net), 32'h7ffa);
        chk("row3_v", 32'(v_net), 32'h008);

        // Write held across the swap-sample cycle lands in the new back buffer.
        goto_t(FRAME - 1);
        bus.wr_valid = 1'b1; bus.wr_row = 4'd1; bus.wr_data = 15'h1234; bus.swap_req = 1'b1;
        #1;
        chk("wr_ready_swap_cycle", 32'(bus.wr_ready), 0);
        step();
        #1;
        chk("wr_ready_after_swap", 32'(bus.wr_ready), 1);
        chk("swap_ack_stalled", 32'(bus.swap_ack), 1);
        step();
        bus.wr_valid = 1'b0; bus.swap_req = 1'b0;
        goto_t(ROWP + BL);
        #1;
        chk("row1_hidden", 32'(h_net), 32'h7fff);
        do_swap();
        goto_t(ROWP + BL);
        #1;
        chk("row1_shown", 32'(h_net), 32'h6dcb);

        // swap_req held: exactly three acks, one frame apart.
        acks = 0; last = 0;
        bus.swap_req = 1'b1;
        for (int n = 0; n < 4 * FRAME && acks < 3; n++) begin
            #1;
            if (bus.swap_ack) begin
                if (acks > 0) chk("ack_spacing", 32'(cyc - last), FRAME);
                last = cyc;
                acks++;
            end
            step();
        end
        bus.swap_req = 1'b0;
        extra = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            #1;
            extra += int'(bus.swap_ack);
            step();
        end
        chk("ack_count", 32'(acks), 3);
        chk("ack_extra", 32'(extra), 0);

        // Fill the display, then reset during row 5 ON.
        for (int r = 0; r < HEIGHT; r++) begin
            bus.wr_valid = 1'b1; bus.wr_row = 4'(r); bus.wr_data = 15'h7fff;
            step();
        end
        bus.wr_valid = 1'b0;
        do_swap();
        goto_t(5 * ROWP + BL + 1);
        #1;
        chk("row5_lit_before_reset", 32'(h_net), 32'h0000);
        rst = 1'b1;
        step();
        #1;
        chk("reset_v_off", 32'(v_net), 0);
        chk("reset_h_off", 32'(h_net), 32'h7fff);
        chk("reset_wr_ready", 32'(bus.wr_ready), 0);
        step();
        rst = 1'b0;
        #1;
        chk("frame_start_after_reset", 32'(frame_start), 1);
        frame_all_dark("cleared_h");

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 15 * FRAME; n++) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_row   = 4'($urandom_range(0, 15));
            bus.wr_data  = 15'($urandom);
            bus.swap_req = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        bus.swap_req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
